// File: rtl/pb_pkg.sv
// Shared definitions for the push-button front end: debouncer state encoding
// and the level each state presents downstream.
package pb_pkg;

    // 2-bit state encoding shared with the one-pulser-side FSMs.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK_HI = 2'd1,
        HIGH     = 2'd2,
        CHECK_LO = 2'd3
    } pb_state_e;

    localparam int unsigned PB_STATE_W = 2;

    // Debounced level presented while in a given state: the output only flips
    // once a candidate change has been confirmed, so CHECK_LO still reads high.
    function automatic logic pb_state_level(input pb_state_e s);
        return (s == HIGH) || (s == CHECK_LO);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Two-stage capture; only q may be consumed by synchronous logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pb_debouncer.sv
// Push-button debouncer: synchronises the raw button, then requires
// STABLE_CYCLES consecutive agreeing samples before moving db_level.
// Emits registered one-cycle rise/fall strobes on confirmed changes.
module pb_debouncer
    import pb_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 500000,  // must be >= 2
    parameter int unsigned CNT_WIDTH     = 19       // 2**CNT_WIDTH > STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 btn_sync;
    pb_state_e            state_q;
    pb_state_e            state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 rise_d;
    logic                 fall_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_sync)
    );

    // Next-state: count agreeing samples in CHECK_*, any disagreement aborts.
    // The counter is cleared on every state exit so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = CHECK_HI;
                    cnt_d   = '0;
                end
            end
            CHECK_HI: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!btn_sync) begin
                    state_d = CHECK_LO;
                    cnt_d   = '0;
                end
            end
            CHECK_LO: begin
                if (btn_sync) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; db_level tracks the next state so
    // it changes on the same edge as the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_level <= pb_state_level(state_d);
            db_rise  <= rise_d;
            db_fall  <= fall_d;
        end
    end

endmodule

// File: tb/tb_pb_debouncer.sv
// Self-checking bench for pb_debouncer with a short stability window.
module tb_pb_debouncer;

    localparam int unsigned S  = 4;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic db_level;
    logic db_rise;
    logic db_fall;

    int nchk = 0;
    int nbad = 0;

    pb_debouncer #(
        .STABLE_CYCLES (S),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall)
    );

    always #5 clk = ~clk;

    // Reference: the input reaches the decision point two edges late; the level
    // flips once the delayed input has disagreed with it on S+1 consecutive edges.
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_level = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    int   m_run = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0;
            m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0;
        end else begin
            m_s1   <= btn_raw;
            m_s2   <= m_s1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_s2 == m_level) begin
                m_run <= 0;
            end else if (m_run + 1 > int'(S)) begin
                m_level <= m_s2;
                m_run   <= 0;
                m_rise  <= m_s2;
                m_fall  <= ~m_s2;
            end else begin
                m_run <= m_run + 1;
            end
        end
    end

    // Downstream one-pulser: one SP pulse per rising edge of db_level.
    logic sp_prev = 1'b0;
    logic sp;
    always @(posedge clk or negedge rst) begin
        if (!rst) sp_prev <= 1'b0;
        else      sp_prev <= db_level;
    end
    assign sp = db_level & ~sp_prev;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_raw = 1'b0;
        tick(); tick();
        nchk++; if (db_level !== 1'b0) begin nbad++; $display("FAIL reset_level got=%b want=0", db_level); end
        nchk++; if (db_rise !== 1'b0) begin nbad++; $display("FAIL reset_rise got=%b want=0", db_rise); end
        nchk++; if (db_fall !== 1'b0) begin nbad++; $display("FAIL reset_fall got=%b want=0", db_fall); end
    endtask

    // Press held from before edge 0: level and rise appear after edge S+2.
    task automatic test_latency();
        btn_raw = 1'b1;
        rst = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            nchk++;
            if (db_level !== (e >= 6)) begin
                nbad++; $display("FAIL latency_level edge=%0d got=%b want=%b", e, db_level, e >= 6);
            end
            nchk++;
            if (db_rise !== (e == 6)) begin
                nbad++; $display("FAIL latency_rise edge=%0d got=%b want=%b", e, db_rise, e == 6);
            end
        end
    endtask

    task automatic test_release();
        btn_raw = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            nchk++;
            if (db_fall !== (e == 6)) begin
                nbad++; $display("FAIL release_fall edge=%0d got=%b want=%b", e, db_fall, e == 6);
            end
            nchk++;
            if (db_level !== (e < 6)) begin
                nbad++; $display("FAIL release_level edge=%0d got=%b want=%b", e, db_level, e < 6);
            end
        end
    endtask

    // A 3-cycle pulse is shorter than the window and must be rejected.
    task automatic test_glitch();
        for (int i = 0; i < 14; i++) begin
            btn_raw = (i < 3);
            tick();
            nchk++;
            if (db_level !== 1'b0 || db_rise !== 1'b0) begin
                nbad++; $display("FAIL glitch cyc=%0d got level=%b rise=%b want 0/0", i, db_level, db_rise);
            end
        end
    endtask

    // Bounce 1,0,1,0 then steady 1 from edge 4: single rise after edge 10.
    task automatic test_bounce();
        int rises = 0;
        for (int i = 0; i < 16; i++) begin
            btn_raw = (i >= 4) ? 1'b1 : ((i % 2) == 0);
            tick();
            if (db_rise === 1'b1) rises++;
            nchk++;
            if (db_rise !== (i == 10)) begin
                nbad++; $display("FAIL bounce_rise edge=%0d got=%b want=%b", i, db_rise, i == 10);
            end
        end
        nchk++;
        if (rises != 1) begin nbad++; $display("FAIL bounce_count got=%0d want=1", rises); end
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    // Asynchronous reset mid-count, in CHECK_HI and in CHECK_LO.
    task automatic test_midreset();
        btn_raw = 1'b1;
        for (int e = 0; e <= 4; e++) tick();
        #3 rst = 1'b0;
        #1;
        nchk++;
        if (db_level !== 1'b0 || db_rise !== 1'b0 || db_fall !== 1'b0) begin
            nbad++; $display("FAIL midreset_hi got=%b%b%b want=000", db_level, db_rise, db_fall);
        end
        tick();
        rst = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            nchk++;
            if (db_level !== (e >= 6) || db_rise !== (e == 6)) begin
                nbad++; $display("FAIL midreset_relatch edge=%0d got level=%b rise=%b", e, db_level, db_rise);
            end
        end
        btn_raw = 1'b0;
        for (int e = 0; e <= 4; e++) tick();
        nchk++;
        if (db_level !== 1'b1) begin nbad++; $display("FAIL midreset_checklo_level got=%b want=1", db_level); end
        #3 rst = 1'b0;
        #1;
        nchk++;
        if (db_level !== 1'b0 || db_fall !== 1'b0) begin
            nbad++; $display("FAIL midreset_lo got level=%b fall=%b want 0/0", db_level, db_fall);
        end
        tick();
        rst = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            nchk++;
            if (db_level !== 1'b0 || db_rise !== 1'b0 || db_fall !== 1'b0) begin
                nbad++; $display("FAIL midreset_exit edge=%0d got=%b%b%b want=000", e, db_level, db_rise, db_fall);
            end
        end
    endtask

    task automatic cmp_model(input string tag, input int cyc);
        nchk++;
        if (db_level !== m_level || db_rise !== m_rise || db_fall !== m_fall) begin
            nbad++;
            $display("FAIL %s cyc=%0d got=%b%b%b want=%b%b%b", tag, cyc,
                     db_level, db_rise, db_fall, m_level, m_rise, m_fall);
        end
        nchk++;
        if (db_rise === 1'b1 && db_fall === 1'b1) begin
            nbad++; $display("FAIL %s_both cyc=%0d got rise=1 fall=1", tag, cyc);
        end
    endtask

    // Bouncy presses through the one-pulser, then free-running noise.
    task automatic test_random();
        int sp_cnt = 0;
        int cyc = 0;
        int presses = 8;
        for (int p = 0; p < presses; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                int nb = $urandom_range(0, 6);
                for (int i = 0; i < nb; i++) begin
                    btn_raw = 1'($urandom_range(0, 1));
                    tick(); cyc++;
                    if (sp === 1'b1) sp_cnt++;
                    cmp_model("rand_press", cyc);
                end
                btn_raw = (ph == 0);
                for (int i = 0; i < 12; i++) begin
                    tick(); cyc++;
                    if (sp === 1'b1) sp_cnt++;
                    cmp_model("rand_press", cyc);
                end
            end
        end
        nchk++;
        if (sp_cnt != presses) begin nbad++; $display("FAIL sp_pulses got=%0d want=%0d", sp_cnt, presses); end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) btn_raw = ~btn_raw;
            tick(); cyc++;
            cmp_model("rand_noise", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_release();
        test_glitch();
        test_bounce();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
